// File: rtl/config_pkg.sv
// Shared configuration constants for the fetch/decode front end.
// Holds the datapath width, the 4-bit instruction-class bit positions
// (also used by the BTB and RAS) and the control-transfer opcodes.
package config_pkg;

  localparam int unsigned XLEN = 64;

  // Bit positions inside a 4-bit class vector {Call, Return, Jump, Branch}
  localparam int unsigned ClassCall   = 3;
  localparam int unsigned ClassReturn = 2;
  localparam int unsigned ClassJump   = 1;
  localparam int unsigned ClassBranch = 0;

  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;

  // x1 (ra) and x5 (t0) are the link registers recognised by the RAS
  function automatic logic isLinkReg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/class_decode.sv
// Combinational control-transfer classifier.
// Ports: Instr (32-bit expanded instruction) -> InstrClass {Call, Return, Jump, Branch}.
// Shared with the BTB update path.
module class_decode
  import config_pkg::*;
(
  input  logic [31:0] Instr,
  output logic [3:0]  InstrClass
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] funct3;
  logic       isJal;
  logic       isJalr;
  logic       isBranch;
  logic       isCall;
  logic       isReturn;
  logic       unusedImm;

  assign opcode = Instr[6:0];
  assign rd     = Instr[11:7];
  assign funct3 = Instr[14:12];
  assign rs1    = Instr[19:15];

  // Immediate bits carry no class information
  assign unusedImm = ^Instr[31:20];

  assign isJal    = (opcode == OpcodeJal);
  assign isJalr   = (opcode == OpcodeJalr) && (funct3 == 3'b000);
  assign isBranch = (opcode == OpcodeBranch);

  // A jump writing a link register is a call even if rs1 is also a link register
  assign isCall   = (isJal || isJalr) && isLinkReg(rd);
  assign isReturn = isJalr && isLinkReg(rs1) && (rd == 5'd0) && !isCall;

  always_comb begin
    InstrClass              = '0;
    InstrClass[ClassCall]   = isCall;
    InstrClass[ClassReturn] = isReturn;
    InstrClass[ClassJump]   = (isJal || isJalr) && !isCall && !isReturn;
    InstrClass[ClassBranch] = isBranch;
  end

endmodule

// File: rtl/flopenr.sv
// Enabled flop with synchronous active-high reset.
// Ports: clk, reset, en (load enable), d (next value), q (state).
module flopenr #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/flopenrc.sv
// Enabled flop with synchronous reset and synchronous clear.
// Clear only takes effect when enabled, so a stalled stage ignores flush.
// Ports: clk, reset, clear, en (load enable), d (next value), q (state).
module flopenrc #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      if (clear) q <= '0;
      else       q <= d;
    end
  end

endmodule

// File: rtl/instr_class_pipe.sv
// Instruction-class pipeline for the branch predictor.
// Decodes the D-stage instruction class, compares it with the class predicted
// at fetch, and carries class and link address down through E and M.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   StallD/E/M, FlushD/E/M      per-stage stall (hold) and flush (clear)
//   BPClassF                    predicted class from fetch
//   InstrD, CompressedD, PCD    decode-stage instruction, 16-bit origin flag, PC
//   ClassD, ClassE              actual class in D and E
//   ReturnD, CallE, ReturnE     individual class bits
//   BPReturnWrongD, BPClassWrongD  prediction mismatch flags
//   PCLinkE                     address after the E-stage instruction
//   ClassWrongCount             saturating class-mispredict counter
module instr_class_pipe #(
  parameter int unsigned XLEN                 = config_pkg::XLEN,
  parameter bit          COMPRESSED_SUPPORTED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            StallE,
  input  logic            StallM,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            FlushM,
  input  logic [3:0]      BPClassF,
  input  logic [31:0]     InstrD,
  input  logic            CompressedD,
  input  logic [XLEN-1:0] PCD,
  output logic [3:0]      ClassD,
  output logic [3:0]      ClassE,
  output logic            ReturnD,
  output logic            CallE,
  output logic            ReturnE,
  output logic            BPReturnWrongD,
  output logic            BPClassWrongD,
  output logic [XLEN-1:0] PCLinkE,
  output logic [15:0]     ClassWrongCount
);

  import config_pkg::*;

  logic [3:0]      BPClassD;
  logic [3:0]      ClassM;
  logic [XLEN-1:0] PCLinkD;
  logic            countEn;
  logic            unusedClassM;

  class_decode decode (
    .Instr     (InstrD),
    .InstrClass(ClassD)
  );

  flopenrc #(.Width(4)) bpClassDReg (
    .clk  (clk),
    .reset(reset),
    .clear(FlushD),
    .en   (~StallD),
    .d    (BPClassF),
    .q    (BPClassD)
  );

  assign BPClassWrongD  = (BPClassD != ClassD);
  assign BPReturnWrongD = (BPClassD[ClassReturn] != ClassD[ClassReturn]);
  assign ReturnD        = ClassD[ClassReturn];

  assign PCLinkD = PCD + ((CompressedD && COMPRESSED_SUPPORTED) ? XLEN'(2) : XLEN'(4));

  flopenrc #(.Width(4)) classEReg (
    .clk  (clk),
    .reset(reset),
    .clear(FlushE),
    .en   (~StallE),
    .d    (ClassD),
    .q    (ClassE)
  );

  flopenrc #(.Width(XLEN)) pcLinkEReg (
    .clk  (clk),
    .reset(reset),
    .clear(FlushE),
    .en   (~StallE),
    .d    (PCLinkD),
    .q    (PCLinkE)
  );

  flopenrc #(.Width(4)) classMReg (
    .clk  (clk),
    .reset(reset),
    .clear(FlushM),
    .en   (~StallM),
    .d    (ClassE),
    .q    (ClassM)
  );

  // ClassM feeds later-stage logic outside this block
  assign unusedClassM = ^ClassM;

  assign CallE   = ClassE[ClassCall];
  assign ReturnE = ClassE[ClassReturn];

  // Count only mispredictions that actually advance into E; stop at all-ones
  assign countEn = BPClassWrongD && !StallE && !FlushE && (ClassWrongCount != 16'hFFFF);

  flopenr #(.Width(16)) classWrongCountReg (
    .clk  (clk),
    .reset(reset),
    .en   (countEn),
    .d    (ClassWrongCount + 16'd1),
    .q    (ClassWrongCount)
  );

endmodule

// File: tb/tb_instr_class_pipe.sv
module tb_instr_class_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD, StallE, StallM, FlushD, FlushE, FlushM;
  logic [3:0]  BPClassF;
  logic [31:0] InstrD;
  logic        CompressedD;
  logic [63:0] PCD;
  logic [3:0]  ClassD, ClassE;
  logic        ReturnD, CallE, ReturnE, BPReturnWrongD, BPClassWrongD;
  logic [63:0] PCLinkE;
  logic [15:0] ClassWrongCount;

  instr_class_pipe #(.XLEN(64), .COMPRESSED_SUPPORTED(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallD         (StallD),
    .StallE         (StallE),
    .StallM         (StallM),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .FlushM         (FlushM),
    .BPClassF       (BPClassF),
    .InstrD         (InstrD),
    .CompressedD    (CompressedD),
    .PCD            (PCD),
    .ClassD         (ClassD),
    .ClassE         (ClassE),
    .ReturnD        (ReturnD),
    .CallE          (CallE),
    .ReturnE        (ReturnE),
    .BPReturnWrongD (BPReturnWrongD),
    .BPClassWrongD  (BPClassWrongD),
    .PCLinkE        (PCLinkE),
    .ClassWrongCount(ClassWrongCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] instr;
    bit          comp;
    logic [63:0] pc;
    logic [3:0]  bpf;
    bit          sD, sE, sM, fD, fE, fM;
  } stim_t;

  typedef struct {
    logic [3:0]  classD;
    logic        returnD, wrongD, retWrongD;
    logic [3:0]  classE;
    logic        callE, returnE;
    logic [63:0] linkE;
    logic [15:0] count;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t monExp;

  // Reference model state (visible outputs only, by stage)
  bit          mValid = 1'b0;
  logic [3:0]  mBp;
  logic [3:0]  mClsE;
  logic [63:0] mLinkE;
  int          mCnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Class straight from the ISA rules: which jumps link, which return
  function automatic logic [3:0] refClass(input logic [31:0] i);
    logic [6:0] op;
    logic [4:0] rd, rs1;
    bit jal, jalr, br, rdLink, rs1Link, call, ret, jmp;
    op      = i[6:0];
    rd      = i[11:7];
    rs1     = i[19:15];
    jal     = (op == 7'h6F);
    jalr    = (op == 7'h67) && (i[14:12] == 3'd0);
    br      = (op == 7'h63);
    rdLink  = (rd == 5'd1) || (rd == 5'd5);
    rs1Link = (rs1 == 5'd1) || (rs1 == 5'd5);
    call    = (jal || jalr) && rdLink;
    ret     = jalr && rs1Link && (rd == 5'd0) && !call;
    jmp     = (jal || jalr) && !call && !ret;
    return {call, ret, jmp, br};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.instr = 32'h0000_0013; s.comp = 0; s.pc = 64'h0; s.bpf = 4'h0;
    s.sD = 0; s.sE = 0; s.sM = 0; s.fD = 0; s.fE = 0; s.fM = 0;
    return s;
  endfunction

  function automatic logic [4:0] pickReg();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return r[4:0];
    endcase
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    logic [31:0] r;
    logic [6:0]  op;
    logic [2:0]  f3;
    s = idle();
    r = $urandom();
    f3 = 3'd0;
    case ($urandom_range(0, 5))
      0: op = 7'h6F;
      1: op = 7'h67;
      2: begin op = 7'h63; f3 = r[14:12]; end
      3: op = 7'h13;
      4: begin op = r[6:0]; f3 = r[14:12]; end
      default: begin op = 7'h67; f3 = r[14:12]; end
    endcase
    s.instr = {r[31:20], pickReg(), f3, pickReg(), op};
    case ($urandom_range(0, 4))
      0:       s.bpf = 4'h0;
      default: s.bpf = 4'h1 << $urandom_range(0, 3);
    endcase
    s.comp = ($urandom_range(0, 1) == 1);
    s.pc   = {$urandom(), $urandom()};
    if ($urandom_range(0, 9) == 0) s.pc = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(0, 3));
    s.sD = ($urandom_range(0, 6) == 0);
    s.sE = ($urandom_range(0, 6) == 0);
    s.sM = ($urandom_range(0, 6) == 0);
    s.fD = ($urandom_range(0, 6) == 0);
    s.fE = ($urandom_range(0, 6) == 0);
    s.fM = ($urandom_range(0, 6) == 0);
    s.rst = ($urandom_range(0, 99) == 0);
    return s;
  endfunction

  // Applies one cycle of stimulus, queues the outputs expected at this cycle's
  // sample point, then advances the model across the coming clock edge.
  task automatic step(input stim_t s);
    exp_t       e;
    logic [3:0] cd;
    @(posedge clk);
    #1;
    reset = s.rst; InstrD = s.instr; CompressedD = s.comp; PCD = s.pc; BPClassF = s.bpf;
    StallD = s.sD; StallE = s.sE; StallM = s.sM; FlushD = s.fD; FlushE = s.fE; FlushM = s.fM;
    cd = refClass(s.instr);
    if (mValid) begin
      e.classD    = cd;
      e.returnD   = cd[2];
      e.wrongD    = (mBp != cd);
      e.retWrongD = (mBp[2] != cd[2]);
      e.classE    = mClsE;
      e.callE     = mClsE[3];
      e.returnE   = mClsE[2];
      e.linkE     = mLinkE;
      e.count     = 16'(mCnt);
      expQ.push_back(e);
    end
    if (s.rst) begin
      mBp = 4'h0; mClsE = 4'h0; mLinkE = 64'h0; mCnt = 0; mValid = 1'b1;
    end else begin
      if (!s.sE && !s.fE && (mBp != cd) && mCnt < 65535) mCnt = mCnt + 1;
      if (!s.sD) mBp = s.fD ? 4'h0 : s.bpf;
      if (!s.sE) begin
        mClsE  = s.fE ? 4'h0 : cd;
        mLinkE = s.fE ? 64'h0 : s.pc + (s.comp ? 64'd2 : 64'd4);
      end
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      check("ClassD", 64'(ClassD), 64'(monExp.classD));
      check("ReturnD", 64'(ReturnD), 64'(monExp.returnD));
      check("BPClassWrongD", 64'(BPClassWrongD), 64'(monExp.wrongD));
      check("BPReturnWrongD", 64'(BPReturnWrongD), 64'(monExp.retWrongD));
      check("ClassE", 64'(ClassE), 64'(monExp.classE));
      check("CallE", 64'(CallE), 64'(monExp.callE));
      check("ReturnE", 64'(ReturnE), 64'(monExp.returnE));
      check("PCLinkE", PCLinkE, monExp.linkE);
      check("ClassWrongCount", 64'(ClassWrongCount), 64'(monExp.count));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    reset = 1'b1; InstrD = 32'h13; CompressedD = 0; PCD = '0; BPClassF = '0;
    StallD = 0; StallE = 0; StallM = 0; FlushD = 0; FlushE = 0; FlushM = 0;

    s = idle(); s.rst = 1; s.sE = 1; s.fD = 1;   // reset wins over stall/flush
    step(s);
    step(s);

    // Reset state, then jalr x1,0(x1) mispredicted as nothing
    step(idle());
    @(negedge clk);
    check("reset ClassE", 64'(ClassE), 64'h0);
    check("reset PCLinkE", PCLinkE, 64'h0);
    check("reset count", 64'(ClassWrongCount), 64'h0);
    s = idle(); s.instr = 32'h0000_80E7;
    step(s);
    @(negedge clk);
    check("call ClassD", 64'(ClassD), 64'h8);
    check("call BPClassWrongD", 64'(BPClassWrongD), 64'h1);
    check("call count before", 64'(ClassWrongCount), 64'h0);
    step(idle());
    @(negedge clk);
    check("call CallE", 64'(CallE), 64'h1);
    check("call count after", 64'(ClassWrongCount), 64'h1);

    // Correctly predicted return
    s = idle(); s.bpf = 4'h4;
    step(s);
    s = idle(); s.instr = 32'h0000_8067;
    step(s);
    @(negedge clk);
    check("ret ReturnD", 64'(ReturnD), 64'h1);
    check("ret BPReturnWrongD", 64'(BPReturnWrongD), 64'h0);
    check("ret BPClassWrongD", 64'(BPClassWrongD), 64'h0);

    // Predicted return, actual NOP
    s = idle(); s.bpf = 4'h4;
    step(s);
    step(idle());
    @(negedge clk);
    check("nop BPReturnWrongD", 64'(BPReturnWrongD), 64'h1);
    step(idle());
    @(negedge clk);
    check("nop ReturnE", 64'(ReturnE), 64'h0);

    // Link address wrap and plain +4
    s = idle(); s.pc = 64'hFFFF_FFFF_FFFF_FFFE; s.comp = 1;
    step(s);
    step(idle());
    @(negedge clk);
    check("link wrap", PCLinkE, 64'h0);
    s = idle(); s.pc = 64'h1000;
    step(s);
    step(idle());
    @(negedge clk);
    check("link +4", PCLinkE, 64'h1004);

    // Stall beats flush in E
    s = idle(); s.instr = 32'h0000_80E7;
    step(s);
    s = idle(); s.sE = 1; s.fE = 1;
    step(s);
    @(negedge clk);
    check("stallE before", 64'(ClassE), 64'h8);
    s = idle(); s.fE = 1;
    step(s);
    @(negedge clk);
    check("stallE held", 64'(ClassE), 64'h8);
    step(idle());
    @(negedge clk);
    check("stallE released", 64'(ClassE), 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) step(randStim());

    // Saturation: 65537 mispredicted calls from a cleared counter
    s = idle(); s.rst = 1;
    step(s);
    s = idle(); s.instr = 32'h0000_80E7;
    for (int i = 0; i < 65537; i++) step(s);
    step(idle());
    @(negedge clk);
    check("count saturated", 64'(ClassWrongCount), 64'hFFFF);
    s = idle(); s.rst = 1;
    step(s);
    step(idle());
    @(negedge clk);
    check("count after reset", 64'(ClassWrongCount), 64'h0);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_class_pipe.md
INSTR_CLASS_PIPE -- requirements
Module: instr_class_pipe

Interface
REQ-001 SHALL take parameter XLEN, default 64, datapath width (from config_pkg).
REQ-002 SHALL take parameter COMPRESSED_SUPPORTED, default 1; when 1, 16-bit instructions advance the link address by 2.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports StallD, StallE, StallM, FlushD, FlushE, FlushM, each input, 1, pipeline stage stall and flush controls.
REQ-006 SHALL have port BPClassF, input, 4, predicted class {Call, Return, Jump, Branch}; one-hot or zero.
REQ-007 SHALL have port InstrD, input, 32, decode-stage instruction (already expanded if compressed).
REQ-008 SHALL have port CompressedD, input, 1, InstrD originated from a 16-bit encoding.
REQ-009 SHALL have port PCD, input, XLEN, decode-stage PC.
REQ-010 SHALL have output ports ClassD and ClassE, each 4 bits, actual class in D and in E.
REQ-011 SHALL have output ports ReturnD, CallE and ReturnE, each 1 bit, individual class bits.
REQ-012 SHALL have output ports BPReturnWrongD and BPClassWrongD, each 1 bit, prediction-mismatch flags.
REQ-013 SHALL have port PCLinkE, output, XLEN, address of the instruction after the E-stage instruction.
REQ-014 SHALL have port ClassWrongCount, output, 16, saturating count of class mispredictions.

Function
REQ-015 SHALL decode ClassD combinationally from InstrD:
- JAL = opcode 1101111.
- JALR = opcode 1100111 with funct3 000.
- Branch = opcode 1100011.
REQ-016 SHALL set Call = (JAL or JALR) with rd in {x1, x5}.
REQ-017 SHALL set Return = JALR with rs1 in {x1, x5} and rd = x0.
REQ-018 SHALL set Jump = (JAL or JALR) and not Call and not Return; Call has priority over Return.
REQ-019 SHALL register BPClassF into BPClassD with these rules:
- if StallD, hold;
- else if FlushD, clear to 0;
- else load.
Flush is ignored while stalled.
REQ-020 SHALL compute BPClassWrongD = (BPClassD != ClassD) and BPReturnWrongD = (BPClassD.Return != ClassD.Return), both combinational in D.
REQ-021 SHALL register ClassD into ClassE and PCLinkD into PCLinkE under StallE/FlushE, same priority as REQ-019.
REQ-022 SHALL register ClassE into ClassM under StallM/FlushM, same priority as REQ-019; ClassM is internal.
REQ-023 SHALL compute PCLinkD = PCD + 2 when CompressedD and COMPRESSED_SUPPORTED, else PCD + 4, modulo 2^XLEN.
REQ-024 SHALL drive CallE = ClassE.Call, ReturnE = ClassE.Return and ReturnD = ClassD.Return.
REQ-025 SHALL increment ClassWrongCount by 1 in any cycle with BPClassWrongD & ~StallE & ~FlushE.
REQ-026 SHALL hold ClassWrongCount at FFFF once it saturates, with no wrap.
REQ-027 SHALL treat a flushed D instruction (NOP 00000013) as class 0000, producing no mismatch unless BPClassD is nonzero.
REQ-028 SHALL give a held stage identical outputs on every stalled cycle; stall and flush of different stages are independent.

Reset
REQ-029 SHALL clear BPClassD, ClassE, ClassM and PCLinkE to 0 while reset is high.
REQ-030 SHALL clear ClassWrongCount to 0 while reset is high.
REQ-031 SHALL give reset priority over stall and flush, including reset asserted mid-pipeline.

Structure
REQ-032 SHALL define the 4-bit class bit positions (Call=3, Return=2, Jump=1, Branch=0) as constants in config_pkg, shared with the BTB and RAS.
REQ-033 SHALL place the opcode constants for JAL, JALR and BRANCH in the same shared package.
REQ-034 SHALL instantiate one sub-module, class_decode: a combinational InstrD-to-ClassD decoder reused by the BTB update path.
REQ-035 SHALL build all pipeline registers from the team's flopenrc/flopenr primitives.

Verification
REQ-036 SHALL cover: InstrD=000080E7 (jalr x1,0(x1)), BPClassF=0000 -> ClassD=1000; next cycle CallE=1; BPClassWrongD=1; count 0->1.
REQ-037 SHALL cover: InstrD=00008067 (ret), BPClassF=0100 one cycle earlier -> ReturnD=1, BPReturnWrongD=0, BPClassWrongD=0.
REQ-038 SHALL cover: BPClassF=0100 registered, then InstrD=00000013 -> BPReturnWrongD=1; next cycle ReturnE=0.
REQ-039 SHALL cover: PCD=FFFF_FFFF_FFFF_FFFE, CompressedD=1 -> PCLinkE=0 (wrap).
REQ-039a SHALL cover: PCD=1000, CompressedD=0 -> PCLinkE=1004.
REQ-040 SHALL cover: StallE=1 and FlushE=1 with ClassE=1000 -> ClassE holds 1000; deassert StallE -> ClassE=0000 next cycle.
REQ-041 SHALL cover: 65537 consecutive mispredicted calls -> ClassWrongCount=FFFF; reset -> 0 on the next edge.
